// File: rtl/whack_pkg.sv
// Shared types and constants for the mole round logic.
// Holds the FSM state enum, LFSR geometry/taps and the round-counter ceiling.
package whack_pkg;

  typedef enum logic [1:0] {
    IDLE,
    GAP,
    UP
  } state_t;

  localparam int LFSR_W = 8;
  // Fibonacci taps for x^8+x^6+x^5+x^4+1, shifting toward the MSB
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'b1011_1000;
  localparam logic [7:0] ROUNDS_MAX = 8'd255;

  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] v);
    return {v[LFSR_W-2:0], ^(v & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/mole_hit_unit_if.sv
// Game control in, mole state and judgement pulses out.
// master drives start/stop/keys; slave is the mole unit.
interface mole_hit_unit_if #(
  parameter int NUM_HOLES = 4
) ();

  logic                         start;
  logic                         stop;
  logic [NUM_HOLES-1:0]         keys;
  logic [$clog2(NUM_HOLES)-1:0] mole_pos;
  logic                         mole_valid;
  logic                         hit;
  logic                         miss;
  logic [7:0]                   rounds;

  modport master (
    output start, stop, keys,
    input  mole_pos, mole_valid, hit, miss, rounds
  );

  modport slave (
    input  start, stop, keys,
    output mole_pos, mole_valid, hit, miss, rounds
  );

endinterface

// File: rtl/key_sync_edge.sv
// Per-key 2-flop synchronizer followed by a registered rising-edge pulse.
// Latency: raw key sampled at edge N gives kedge high after edge N+2.
module key_sync_edge #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] keys,
  output logic [WIDTH-1:0] kedge
);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      prev  <= '0;
      kedge <= '0;
    end else begin
      sync1 <= keys;
      sync2 <= sync1;
      prev  <= sync2;
      kedge <= sync2 & ~prev;
    end
  end

endmodule

// File: rtl/mole_hit_unit.sv
// Runs mole rounds: gap, raise a mole in a pseudo-random hole, judge keys into hit/miss pulses.
// hit/miss are registered one cycle after the key edge; stop overrides everything and returns to IDLE.
module mole_hit_unit
  import whack_pkg::*;
#(
  parameter int                NUM_HOLES   = 4,
  parameter int                MOLE_CYCLES = 50_000_000,
  parameter int                GAP_CYCLES  = 12_500_000,
  parameter logic [LFSR_W-1:0] LFSR_SEED   = 8'hA5
) (
  input logic            clk,
  input logic            Resetn,
  mole_hit_unit_if.slave bus
);

  localparam int POS_W   = $clog2(NUM_HOLES);
  localparam int CNT_MAX = (MOLE_CYCLES > GAP_CYCLES) ? MOLE_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] MOLE_LAST = CNT_W'(MOLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);

  state_t               state;
  logic [CNT_W-1:0]     cnt;
  logic [LFSR_W-1:0]    lfsr;
  logic [POS_W-1:0]     mole_pos;
  logic [POS_W-1:0]     next_pos;
  logic                 mole_valid;
  logic                 hit;
  logic                 miss;
  logic [7:0]           rounds;
  logic [NUM_HOLES-1:0] kedge;
  logic                 correct_key;
  logic                 wrong_key;

  key_sync_edge #(
    .WIDTH(NUM_HOLES)
  ) u_key_sync_edge (
    .clk  (clk),
    .rst_n(Resetn),
    .keys (bus.keys),
    .kedge(kedge)
  );

  always_ff @(posedge clk or negedge Resetn) begin
    if (!Resetn) begin
      lfsr <= LFSR_SEED;
    end else begin
      lfsr <= lfsr_step(lfsr);
    end
  end

  // Never raise two moles in a row in the same hole
  always_comb begin
    next_pos = lfsr[POS_W-1:0];
    if (next_pos == mole_pos) begin
      next_pos = next_pos + 1'b1;
    end
  end

  assign correct_key = kedge[mole_pos];
  assign wrong_key   = |(kedge & ~(NUM_HOLES'(1) << mole_pos));

  always_ff @(posedge clk or negedge Resetn) begin
    if (!Resetn) begin
      state      <= IDLE;
      cnt        <= '0;
      mole_pos   <= '0;
      mole_valid <= 1'b0;
      hit        <= 1'b0;
      miss       <= 1'b0;
      rounds     <= '0;
    end else begin
      hit  <= 1'b0;
      miss <= 1'b0;
      if (bus.stop) begin
        state      <= IDLE;
        mole_valid <= 1'b0;
        cnt        <= '0;
      end else begin
        case (state)
          IDLE: begin
            mole_valid <= 1'b0;
            if (bus.start) begin
              rounds <= '0;
              cnt    <= '0;
              state  <= GAP;
            end
          end
          GAP: begin
            if (cnt == GAP_LAST) begin
              cnt        <= '0;
              state      <= UP;
              mole_valid <= 1'b1;
              mole_pos   <= next_pos;
              if (rounds != ROUNDS_MAX) begin
                rounds <= rounds + 1'b1;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          UP: begin
            if (correct_key) begin
              hit        <= 1'b1;
              mole_valid <= 1'b0;
              cnt        <= '0;
              state      <= GAP;
            end else if (wrong_key) begin
              // Wrong key outranks timeout: the timer holds so the timeout still fires next cycle
              miss <= 1'b1;
            end else if (cnt == MOLE_LAST) begin
              miss       <= 1'b1;
              mole_valid <= 1'b0;
              cnt        <= '0;
              state      <= GAP;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: begin
            state      <= IDLE;
            mole_valid <= 1'b0;
            cnt        <= '0;
          end
        endcase
      end
    end
  end

  assign bus.mole_pos   = mole_pos;
  assign bus.mole_valid = mole_valid;
  assign bus.hit        = hit;
  assign bus.miss       = miss;
  assign bus.rounds     = rounds;

endmodule

// File: tb/tb_mole_hit_unit.sv
// Scenario bench for mole_hit_unit with a cycle-count driven reference for hole choice and pulse timing.
module tb_mole_hit_unit;

  localparam int NH = 4;
  localparam int MC = 20;
  localparam int GC = 5;

  logic clk = 1'b0;
  logic Resetn = 1'b0;

  mole_hit_unit_if #(.NUM_HOLES(NH)) bus ();

  mole_hit_unit #(
    .NUM_HOLES  (NH),
    .MOLE_CYCLES(MC),
    .GAP_CYCLES (GC),
    .LFSR_SEED  (8'hA5)
  ) dut (
    .clk   (clk),
    .Resetn(Resetn),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc;
  logic [1:0] exp_prev = 2'd0;
  int exp_rounds = 0;

  // Edges seen since reset released; the LFSR has shifted exactly this many times
  always @(posedge clk or negedge Resetn) begin
    if (!Resetn) cyc <= 0;
    else         cyc <= cyc + 1;
  end

  function automatic logic [7:0] lfsr_after(input int n);
    logic [7:0] v;
    v = 8'hA5;
    for (int i = 0; i < n; i++) v = {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    return v;
  endfunction

  // Hole expected for a mole that rose on the edge just passed
  function automatic logic [1:0] predict_pos();
    logic [7:0] v;
    logic [1:0] p;
    v = lfsr_after(cyc - 1);
    p = v[1:0];
    if (p == exp_prev) p = p + 2'd1;
    return p;
  endfunction

  task automatic wait_mole(output bit ok, output int n);
    ok = 1'b0;
    n  = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      n++;
      if (bus.mole_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Called at the negedge where the mole was first seen (r=0); presses at r, observes until one cycle past the fall
  task automatic play_mole(input int d_wrong, input logic [3:0] wrong_mask,
                           input int d_right, input logic [3:0] right_mask,
                           output int hit_r, output int miss_r, output int hits,
                           output int misses, output int fall_r, output bit pos_stable);
    hit_r = -1; miss_r = -1; hits = 0; misses = 0; fall_r = -1; pos_stable = 1'b1;
    for (int r = 0; r <= 40; r++) begin
      if (r > 0) begin
        @(negedge clk);
        if (bus.hit) begin hits++; if (hit_r < 0) hit_r = r; end
        if (bus.miss) begin misses++; if (miss_r < 0) miss_r = r; end
        if (!bus.mole_valid && fall_r < 0) fall_r = r;
        if (bus.mole_valid && bus.mole_pos !== exp_prev) pos_stable = 1'b0;
      end
      if (fall_r >= 0 && r >= fall_r + 1) break;
      bus.keys = (r == d_wrong) ? wrong_mask : (r == d_right) ? right_mask : 4'b0000;
    end
    bus.keys = 4'b0000;
  endtask

  task automatic end_game();
    bus.stop  = 1'b1;
    bus.start = 1'b0;
    @(negedge clk);
    bus.stop = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [12:0] outs;
    bus.start = 1'b0; bus.stop = 1'b0; bus.keys = 4'b0000;
    Resetn = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      outs = {bus.mole_pos, bus.mole_valid, bus.hit, bus.miss, bus.rounds};
      checks++;
      if (outs !== 13'd0) begin errors++; $display("FAIL reset_outs got=%h want=0", outs); end
      bus.keys  = 4'($urandom);
      bus.start = 1'($urandom);
    end
    bus.keys = 4'b0000; bus.start = 1'b0;
    @(negedge clk);
    Resetn = 1'b1;
    exp_prev = 2'd0;
    repeat (3) @(negedge clk);
    outs = {bus.mole_pos, bus.mole_valid, bus.hit, bus.miss, bus.rounds};
    checks++;
    if (outs !== 13'd0) begin errors++; $display("FAIL idle_after_reset got=%h want=0", outs); end
  endtask

  task automatic test_correct_whack();
    bit ok; int n, hr, mr, hs, ms, fr; bit st; logic [1:0] p, old; logic [3:0] cm;
    bus.start = 1'b1; exp_rounds = 0;
    wait_mole(ok, n);
    checks++;
    if (!ok || n != GC + 1) begin errors++; $display("FAIL first_rise got=%0d want=%0d", n, GC + 1); end
    p = predict_pos();
    checks++;
    if (bus.mole_pos !== p) begin errors++; $display("FAIL whack_pos got=%0d want=%0d", bus.mole_pos, p); end
    exp_prev = p; exp_rounds++;
    cm = 4'b0001 << p;
    play_mole(-1, 4'b0000, 1, cm, hr, mr, hs, ms, fr, st);
    checks++;
    if (hr != 5 || hs != 1 || ms != 0 || fr != 5) begin
      errors++; $display("FAIL whack_hit got hit_r=%0d hits=%0d misses=%0d fall=%0d want 5 1 0 5", hr, hs, ms, fr);
    end
    checks++;
    if (bus.rounds !== 8'd1) begin errors++; $display("FAIL whack_rounds got=%0d want=1", bus.rounds); end
    old = exp_prev;
    wait_mole(ok, n);
    checks++;
    if (!ok || n != GC - 1) begin errors++; $display("FAIL next_rise got=%0d want=%0d", n, GC - 1); end
    p = predict_pos();
    checks++;
    if (bus.mole_pos === old || bus.mole_pos !== p) begin
      errors++; $display("FAIL next_pos got=%0d want=%0d prev=%0d", bus.mole_pos, p, old);
    end
    exp_prev = p; exp_rounds++;
    checks++;
    if (bus.rounds !== 8'd2) begin errors++; $display("FAIL rounds_two got=%0d want=2", bus.rounds); end
    end_game();
  endtask

  task automatic test_timeout();
    bit ok; int n, hr, mr, hs, ms, fr; bit st; logic [1:0] p, old;
    bus.start = 1'b1; exp_rounds = 0;
    for (int k = 0; k < 3; k++) begin
      old = exp_prev;
      wait_mole(ok, n);
      checks++;
      if (!ok || n != ((k == 0) ? GC + 1 : GC - 1)) begin errors++; $display("FAIL to_rise%0d got=%0d", k, n); end
      p = predict_pos();
      checks++;
      if (bus.mole_pos !== p || (k > 0 && bus.mole_pos === old)) begin
        errors++; $display("FAIL to_pos%0d got=%0d want=%0d prev=%0d", k, bus.mole_pos, p, old);
      end
      exp_prev = p; exp_rounds++;
      play_mole(-1, 4'b0000, -1, 4'b0000, hr, mr, hs, ms, fr, st);
      checks++;
      if (fr != MC || mr != MC || ms != 1 || hs != 0 || !st) begin
        errors++; $display("FAIL to_miss%0d got fall=%0d miss_r=%0d misses=%0d hits=%0d want %0d %0d 1 0", k, fr, mr, ms, hs, MC, MC);
      end
    end
    checks++;
    if (bus.rounds !== 8'd3) begin errors++; $display("FAIL to_rounds got=%0d want=3", bus.rounds); end
    end_game();
  endtask

  task automatic test_wrong_then_simultaneous();
    bit ok; int n, hr, mr, hs, ms, fr; bit st; logic [1:0] p, w; logic [3:0] cm, wm;
    bus.start = 1'b1; exp_rounds = 0;
    wait_mole(ok, n);
    p = predict_pos();
    checks++;
    if (!ok || bus.mole_pos !== p) begin errors++; $display("FAIL wr_pos got=%0d want=%0d", bus.mole_pos, p); end
    exp_prev = p;
    w  = p + 2'(1 + $urandom_range(0, 2));
    wm = 4'b0001 << w;
    cm = 4'b0001 << p;
    play_mole(1, wm, 6, cm, hr, mr, hs, ms, fr, st);
    checks++;
    if (mr != 5 || ms != 1 || hr != 10 || hs != 1 || fr != 10 || !st) begin
      errors++; $display("FAIL wrong_right got miss_r=%0d misses=%0d hit_r=%0d hits=%0d fall=%0d stable=%0d want 5 1 10 1 10 1", mr, ms, hr, hs, fr, st);
    end
    wait_mole(ok, n);
    p = predict_pos();
    checks++;
    if (!ok || bus.mole_pos !== p) begin errors++; $display("FAIL all_pos got=%0d want=%0d", bus.mole_pos, p); end
    exp_prev = p;
    play_mole(-1, 4'b0000, 2, 4'b1111, hr, mr, hs, ms, fr, st);
    checks++;
    if (hr != 6 || hs != 1 || ms != 0 || fr != 6) begin
      errors++; $display("FAIL all_keys got hit_r=%0d hits=%0d misses=%0d fall=%0d want 6 1 0 6", hr, hs, ms, fr);
    end
    wait_mole(ok, n);
    p = predict_pos();
    checks++;
    if (!ok || bus.mole_pos !== p) begin errors++; $display("FAIL edge_pos got=%0d want=%0d", bus.mole_pos, p); end
    exp_prev = p;
    cm = 4'b0001 << p;
    play_mole(-1, 4'b0000, MC - 4, cm, hr, mr, hs, ms, fr, st);
    checks++;
    if (hr != MC || hs != 1 || ms != 0 || fr != MC) begin
      errors++; $display("FAIL hit_on_timeout got hit_r=%0d hits=%0d misses=%0d fall=%0d want %0d 1 0 %0d", hr, hs, ms, fr, MC, MC);
    end
    end_game();
  endtask

  task automatic test_random();
    bit ok; int n, hr, mr, hs, ms, fr; bit st; logic [1:0] p, w; logic [3:0] cm, wm;
    int a, dw, dr, e_hr, e_mr, e_hs, e_ms, e_fr;
    bus.start = 1'b1; exp_rounds = 0;
    for (int k = 0; k < 12; k++) begin
      wait_mole(ok, n);
      p = predict_pos();
      checks++;
      if (!ok || n != ((k == 0) ? GC + 1 : GC - 1) || bus.mole_pos !== p) begin
        errors++; $display("FAIL rnd_rise%0d got n=%0d pos=%0d want pos=%0d", k, n, bus.mole_pos, p);
      end
      exp_prev = p; exp_rounds++;
      a  = $urandom_range(0, 2);
      w  = p + 2'(1 + $urandom_range(0, 2));
      wm = 4'b0001 << w;
      cm = 4'b0001 << p;
      dw = -1; dr = -1;
      if (a == 0) begin
        dr = $urandom_range(0, MC - 4);
        e_hr = dr + 4; e_hs = 1; e_mr = -1; e_ms = 0; e_fr = dr + 4;
      end else if (a == 1) begin
        e_hr = -1; e_hs = 0; e_mr = MC; e_ms = 1; e_fr = MC;
      end else begin
        dw = $urandom_range(0, 6);
        dr = dw + $urandom_range(1, 6);
        e_hr = dr + 4; e_hs = 1; e_mr = dw + 4; e_ms = 1; e_fr = dr + 4;
      end
      play_mole(dw, wm, dr, cm, hr, mr, hs, ms, fr, st);
      checks++;
      if (hr != e_hr || mr != e_mr || hs != e_hs || ms != e_ms || fr != e_fr || !st) begin
        errors++;
        $display("FAIL rnd_round%0d act=%0d got hit_r=%0d miss_r=%0d hits=%0d misses=%0d fall=%0d want %0d %0d %0d %0d %0d",
                 k, a, hr, mr, hs, ms, fr, e_hr, e_mr, e_hs, e_ms, e_fr);
      end
    end
    checks++;
    if (bus.rounds !== 8'(exp_rounds)) begin errors++; $display("FAIL rnd_rounds got=%0d want=%0d", bus.rounds, exp_rounds); end
    end_game();
  endtask

  task automatic test_stop_reset();
    bit ok; int n; bit quiet; logic [1:0] p; logic [12:0] outs;
    bus.start = 1'b1;
    wait_mole(ok, n);
    p = predict_pos();
    checks++;
    if (!ok || bus.mole_pos !== p) begin errors++; $display("FAIL sr_pos got=%0d want=%0d", bus.mole_pos, p); end
    exp_prev = p;
    repeat (3) @(negedge clk);
    bus.stop = 1'b1; bus.start = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.mole_valid !== 1'b0 || bus.hit !== 1'b0 || bus.miss !== 1'b0 || bus.rounds !== 8'd1) begin
      errors++; $display("FAIL stop_up got valid=%0d hit=%0d miss=%0d rounds=%0d want 0 0 0 1", bus.mole_valid, bus.hit, bus.miss, bus.rounds);
    end
    bus.stop = 1'b0;
    quiet = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (bus.mole_valid || bus.hit || bus.miss || bus.rounds !== 8'd1) quiet = 1'b0;
    end
    checks++;
    if (!quiet) begin errors++; $display("FAIL stop_idle got=0 want=1"); end
    bus.start = 1'b1;
    wait_mole(ok, n);
    p = predict_pos();
    checks++;
    if (!ok || n != GC + 1 || bus.rounds !== 8'd1 || bus.mole_pos !== p) begin
      errors++; $display("FAIL restart got n=%0d rounds=%0d pos=%0d want %0d 1 %0d", n, bus.rounds, bus.mole_pos, GC + 1, p);
    end
    exp_prev = p;
    repeat (2) @(negedge clk);
    #2 Resetn = 1'b0;
    #1;
    outs = {bus.mole_pos, bus.mole_valid, bus.hit, bus.miss, bus.rounds};
    checks++;
    if (outs !== 13'd0) begin errors++; $display("FAIL async_reset got=%h want=0", outs); end
    bus.start = 1'b0;
    @(negedge clk);
    Resetn = 1'b1;
    exp_prev = 2'd0;
    @(negedge clk);
    bus.start = 1'b1;
    wait_mole(ok, n);
    p = predict_pos();
    checks++;
    if (!ok || n != GC + 1 || bus.mole_pos !== p || bus.rounds !== 8'd1) begin
      errors++; $display("FAIL post_reset got n=%0d pos=%0d rounds=%0d want %0d %0d 1", n, bus.mole_pos, bus.rounds, GC + 1, p);
    end
    exp_prev = p;
    end_game();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_correct_whack();
    test_timeout();
    test_wrong_then_simultaneous();
    test_random();
    test_stop_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mole_hit_unit.md
# mole_hit_unit

Upstream stage of the score datapath. Runs the mole rounds: after `start`, it repeatedly waits a gap, then raises a mole in a pseudo-random hole. It judges the player's pushbuttons against that hole and emits one-cycle `hit`/`miss` pulses. `hit` drives the datapath's player input, and `stop` (the datapath's timer-done) returns the unit to idle.

## Interface
- `NUM_HOLES`, 4: number of holes/keys; power of two, 2..16.
- `MOLE_CYCLES`, 50_000_000: cycles a mole stays up (≥2).
- `GAP_CYCLES`, 12_500_000: cycles between moles (≥1).
- `LFSR_SEED`, 8'hA5: LFSR reset value; must be nonzero.
- `clk`, in, 1: single clock; all logic on rising edge.
- `Resetn`, in, 1: asynchronous, active-low reset.
- `start`, in, 1: level; game running (datapath game_start).
- `stop`, in, 1: level; end game (datapath timer_done).
- `keys`, in, NUM_HOLES: raw active-high pushbuttons, asynchronous to `clk`.
- `mole_pos`, out, $clog2(NUM_HOLES): current hole index.
- `mole_valid`, out, 1: mole is up.
- `hit`, out, 1: one-cycle pulse on a correct whack.
- `miss`, out, 1: one-cycle pulse on a wrong key or timeout.
- `rounds`, out, 8: moles raised since start; saturates at 255.

## Operation
- Reset values:
  - All outputs are 0: `mole_pos`=0, `mole_valid`=0, `hit`=0, `miss`=0, `rounds`=0.
  - FSM is IDLE, counters are 0, LFSR=`LFSR_SEED`.
  - Key synchronizers and edge registers are 0.
- Keys pass through a 2-flop synchronizer, then rising-edge detection; `kedge[i]` is a one-cycle pulse.
- LFSR:
  - 8-bit Fibonacci, polynomial x^8+x^6+x^5+x^4+1.
  - Shifts every cycle out of reset, in every state.
- FSM states: IDLE, GAP, UP.
  - **IDLE**: `mole_valid`=0. If `start`=1 and `stop`=0, clear `rounds` and the counter, go to GAP.
  - **GAP**: count `GAP_CYCLES`, then go to UP.
    - On entry to UP, `mole_pos` = LFSR[log2-1:0].
    - If that value equals the previous `mole_pos`, use (value+1) mod NUM_HOLES instead.
    - `rounds` += 1, saturating at 255.
  - **UP**: `mole_valid`=1, counter runs.
    - `kedge[mole_pos]`=1 → `hit` pulse, go to GAP.
    - Else any `kedge`=1 on another key → `miss` pulse, stay in UP, counter unchanged.
    - Else counter reaches `MOLE_CYCLES` → `miss` pulse, go to GAP.
- Priority within a cycle:
  - `stop` > correct key > wrong key > timeout.
  - Correct plus wrong keys in the same cycle → `hit` only.
  - Correct key on the timeout cycle → `hit` only.
- `stop`=1 in any state → IDLE next cycle, no pulse, `mole_valid`=0. `rounds` holds until the next start.
- `start` dropping while `stop`=0 has no effect once running.
- Key edges in IDLE/GAP are ignored (no `miss`).
- At most one of `hit`/`miss` is high in any cycle.

## Timing
- Key latency: raw key first sampled high at edge N → `kedge` high after edge N+2 → `hit`/`miss` registered, high for the single cycle after edge N+3.
- `mole_valid` rises on the edge that ends GAP (cycle GAP_CYCLES after GAP entry). It falls on the same edge that registers `hit` or the timeout `miss`.
- `mole_pos` is stable while `mole_valid`=1.
- The mole is up for exactly `MOLE_CYCLES` cycles if not hit.
- `Resetn` low mid-round: all state clears immediately, asynchronously. Release is synchronous to `clk`, and the unit restarts from IDLE.

## Structure
- Package `whack_pkg`:
  - FSM state enum (IDLE/GAP/UP).
  - LFSR width and tap constants.
  - `ROUNDS_MAX`=255.
- Sub-module `key_sync_edge`: per-key 2-flop synchronizer plus rising-edge pulse, parameterised by width. Instantiated once with width NUM_HOLES.
- The counter is sized to hold max(MOLE_CYCLES, GAP_CYCLES).

## Test plan
Bench parameters: NUM_HOLES=4, MOLE_CYCLES=20, GAP_CYCLES=5, LFSR_SEED=8'hA5.
- **Reset**: hold `Resetn`=0, toggle `keys` and `start` → all outputs 0; `rounds`=0.
- **Correct whack**: start, wait for `mole_valid`, press `keys[mole_pos]` → `hit` high exactly 1 cycle, 4 cycles after the press. `mole_valid` falls and `rounds`=1. The next mole rises 5 cycles later in a different hole.
- **Timeout**: start, press nothing → `mole_valid` high for 20 cycles, then one `miss` pulse. Over 3 rounds, `rounds`=3 and consecutive `mole_pos` values differ.
- **Wrong then right**: press a wrong key → `miss` pulse, mole stays up, same `mole_pos`. Then press the correct key → `hit`.
- **Simultaneous events**:
  - Press all 4 keys at once → `hit` only.
  - Correct edge on the timeout cycle → `hit`, no `miss`.
- **Stop/reset mid-mole**:
  - `stop`=1 while UP → `mole_valid`=0 next cycle, no pulses, `rounds` held.
  - Restarting with `start` → `rounds` restarts from 1.
  - `Resetn` pulse mid-UP → outputs clear immediately.
